// File: rtl/tt_um_pipelined_mult.sv
// Tiny Tapeout top: byte-serial operand load, STAGES-deep WIDTH x WIDTH multiplier,
// byte-serial product readout with busy/done/err status on uio_out[7:5].
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting operand bytes; start checks both operands are full
// CALC  | product travelling down the pipeline, busy=1
// DONE  | product held, rd strobes step through its bytes, done=1
module tt_um_pipelined_mult #(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int NB = WIDTH / 8;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(NB + 1);
  localparam int RW = $clog2(2 * NB);
  localparam logic [CW-1:0] NB_C = CW'(NB);
  localparam logic [RW-1:0] LAST_C = RW'(2 * NB - 1);
  localparam logic SIGNED_OK = (SIGNED_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      hist_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]   cnt_a_q, cnt_b_q;
  logic [RW-1:0]   rd_ptr_q;
  logic [3:0]      calc_cnt_q;
  logic            signed_q;
  logic            err_q;
  logic [PW-1:0]   pipe_q [STAGES];

  logic wr_e, start_e, rd_e;
  logic acc_start, do_wr, do_rd, set_err;

  assign wr_e    = ena & uio_in[0] & ~hist_q[0];
  assign start_e = ena & uio_in[2] & ~hist_q[2];
  assign rd_e    = ena & uio_in[3] & ~hist_q[3];

  // Sign-extend to the full product width so one unsigned multiply covers both modes.
  function automatic logic [PW-1:0] mul_full(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sm);
    logic [PW-1:0] ax, bx;
    ax = {{WIDTH{sm & a[WIDTH-1]}}, a};
    bx = {{WIDTH{sm & b[WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] op,
                                                input logic [7:0]       d);
    logic [WIDTH+7:0] t;
    t = {d, op};
    return t[WIDTH+7:8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    acc_start = 1'b0;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_e) begin
          if (cnt_a_q == NB_C && cnt_b_q == NB_C) begin
            acc_start = 1'b1;
            state_d   = S_CALC;
          end else begin
            set_err = 1'b1;
          end
        end else if (wr_e) begin
          do_wr = 1'b1;
        end
      end
      S_CALC: begin
        if (start_e || wr_e) set_err = 1'b1;
        if (ena && calc_cnt_q == 4'd0) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_e || wr_e) begin
          set_err = 1'b1;
        end else if (rd_e) begin
          do_rd = 1'b1;
          if (rd_ptr_q == LAST_C) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      rd_ptr_q   <= '0;
      calc_cnt_q <= '0;
      signed_q   <= 1'b0;
      err_q      <= 1'b0;
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
    end else begin
      hist_q <= uio_in[3:0];

      if (do_wr) begin
        if (!uio_in[1]) begin
          a_q <= shift_in(a_q, ui_in);
          if (cnt_a_q != NB_C) cnt_a_q <= cnt_a_q + 1'b1;
        end else begin
          b_q <= shift_in(b_q, ui_in);
          if (cnt_b_q != NB_C) cnt_b_q <= cnt_b_q + 1'b1;
        end
      end

      if (acc_start) begin
        signed_q   <= uio_in[4] & SIGNED_OK;
        err_q      <= 1'b0;
        calc_cnt_q <= 4'(STAGES - 1);
        rd_ptr_q   <= '0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end

      // The pipeline only advances in CALC, so the last stage holds the product in DONE.
      if (state_q == S_CALC && ena) begin
        if (calc_cnt_q != 4'd0) calc_cnt_q <= calc_cnt_q - 4'd1;
        pipe_q[0] <= mul_full(a_q, b_q, signed_q);
        for (int k = 1; k < STAGES; k++) pipe_q[k] <= pipe_q[k-1];
      end

      if (do_rd) begin
        if (rd_ptr_q == LAST_C) begin
          rd_ptr_q <= '0;
          cnt_a_q  <= '0;
          cnt_b_q  <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  logic [PW-1:0] product;
  assign product = pipe_q[STAGES-1];

  always_comb begin
    uo_out = 8'h00;
    if (state_q == S_DONE) uo_out = product[8*rd_ptr_q +: 8];
  end

  assign uio_out = {err_q, state_q == S_DONE, state_q == S_CALC, 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:5], hist_q[1]};

endmodule

// File: tb/tb_tt_um_pipelined_mult.sv
// Directed and randomized bench for tt_um_pipelined_mult; products are checked against
// plain 64-bit integer arithmetic on the operands the bench believes it has written.
module tb_tt_um_pipelined_mult;

  localparam int W  = 32;
  localparam int ST = 4;
  localparam int NB = W / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out, uio_out, uio_oe;

  tt_um_pipelined_mult #(.WIDTH(W), .STAGES(ST), .SIGNED_EN(1)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic sgn = 1'b0;
  logic [W-1:0] ma = '0, mb = '0;
  int ca = 0, cb = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = a;
    ub = b;
    return ua * ub;
  endfunction

  task automatic strobe(input logic [3:0] bits);
    @(negedge clk);
    uio_in = {3'b000, sgn, bits};
    @(negedge clk);
    uio_in = {3'b000, sgn, 4'b0000};
  endtask

  task automatic wr_byte(input logic sel, input logic [7:0] d);
    @(negedge clk);
    ui_in  = d;
    uio_in = {3'b000, sgn, 2'b00, sel, 1'b1};
    @(negedge clk);
    uio_in = {3'b000, sgn, 4'b0000};
    if (!sel) begin
      ma = {d, ma[W-1:8]};
      if (ca < NB) ca++;
    end else begin
      mb = {d, mb[W-1:8]};
      if (cb < NB) cb++;
    end
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < NB; i++) wr_byte(1'b0, a[8*i +: 8]);
    for (int i = 0; i < NB; i++) wr_byte(1'b1, b[8*i +: 8]);
  endtask

  // Start (with extra strobe bits), wait for done, read all bytes; inject_at puts a
  // wr+rd strobe into DONE before reading that byte.
  task automatic run_op(input string tag, input logic [3:0] sbits, input int inject_at);
    logic [63:0] exp;
    int cycles;
    exp = ref_prod(ma, mb, sgn);
    ui_in = 8'($urandom);
    strobe(sbits);
    check({tag, ":busy"}, {63'd0, uio_out[5]}, 64'd1);
    check({tag, ":err_clr"}, {63'd0, uio_out[7]}, 64'd0);
    cycles = 0;
    while (uio_out[6] !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, ":latency"}, 64'(cycles), 64'(ST));
    check({tag, ":busy_done"}, {63'd0, uio_out[5]}, 64'd0);
    for (int i = 0; i < 2 * NB; i++) begin
      if (i == inject_at) begin
        ui_in = 8'($urandom);
        strobe(4'b1001);
        check({tag, ":err_wr_done"}, {63'd0, uio_out[7]}, 64'd1);
      end
      check($sformatf("%s:byte%0d", tag, i), {56'd0, uo_out}, {56'd0, exp[8*i +: 8]});
      strobe(4'b1000);
    end
    check({tag, ":idle_done"}, {63'd0, uio_out[6]}, 64'd0);
    check({tag, ":idle_uo"}, {56'd0, uo_out}, 64'd0);
    ca = 0;
    cb = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int extra, cycles;

    repeat (3) @(negedge clk);
    check("rst_uio_out", {56'd0, uio_out}, 64'd0);
    check("rst_uo_out", {56'd0, uo_out}, 64'd0);
    check("uio_oe", {56'd0, uio_oe}, 64'hE0);
    rst_n = 1'b1;

    // 1: 3 * 5
    load(32'd3, 32'd5);
    run_op("t1", 4'b0100, -1);

    strobe(4'b1000);
    check("rd_idle_no_err", {63'd0, uio_out[7]}, 64'd0);

    // 2: max unsigned
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("t2", 4'b0100, -1);

    // 3: signed -1 * -2, then same operands unsigned
    sgn = 1'b1;
    load(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("t3s", 4'b0100, -1);
    sgn = 1'b0;
    load(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("t3u", 4'b0100, -1);

    // 4: incomplete B, rejected start, then completed and accepted
    for (int i = 0; i < NB; i++) wr_byte(1'b0, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < NB - 1; i++) wr_byte(1'b1, 8'(8'h21 + i));
    strobe(4'b0100);
    check("t4_err", {63'd0, uio_out[7]}, 64'd1);
    check("t4_busy", {63'd0, uio_out[5]}, 64'd0);
    wr_byte(1'b1, 8'h9C);
    run_op("t4", 4'b0100, -1);

    // 6a: wr+rd in DONE sets err and leaves the result alone
    sgn = 1'b1;
    load(32'h8000_0001, 32'h7FFF_FF03);
    run_op("t6a", 4'b0100, 3);
    sgn = 1'b0;

    // 6b: held wr level with changing data writes only once
    @(negedge clk);
    ui_in  = 8'hA5;
    uio_in = 8'b0000_0001;
    repeat (3) begin
      @(negedge clk);
      ui_in = 8'($urandom);
    end
    @(negedge clk);
    uio_in = 8'h00;
    ma = {8'hA5, ma[W-1:8]};
    if (ca < NB) ca++;
    for (int i = 0; i < NB - 1; i++) wr_byte(1'b0, 8'(8'h40 + i));
    for (int i = 0; i < NB; i++) wr_byte(1'b1, 8'(8'hC3 - i));
    run_op("t6b", 4'b0100, -1);

    // 6c: ena=0 with strobes toggling changes nothing
    wr_byte(1'b0, 8'h5A);
    wr_byte(1'b0, 8'h6B);
    ena = 1'b0;
    ui_in = 8'hEE;
    strobe(4'b0001);
    strobe(4'b0011);
    strobe(4'b0100);
    strobe(4'b1000);
    @(negedge clk);
    ena = 1'b1;
    check("t6c_err", {63'd0, uio_out[7]}, 64'd0);
    check("t6c_busy", {63'd0, uio_out[5]}, 64'd0);
    wr_byte(1'b0, 8'h7C);
    wr_byte(1'b0, 8'h8D);
    for (int i = 0; i < NB; i++) wr_byte(1'b1, 8'(8'h13 + 8'h22 * i));
    run_op("t6c", 4'b0100, -1);

    // start+wr together: start wins, the write is dropped
    load(32'h0001_2345, 32'h0000_6789);
    run_op("prio", 4'b0101, -1);

    // 5: reset in CALC
    load(32'h1234_5678, 32'h9ABC_DEF0);
    strobe(4'b0100);
    check("t5_busy", {63'd0, uio_out[5]}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_uio", {56'd0, uio_out}, 64'd0);
    check("t5_rst_uo", {56'd0, uo_out}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ma = '0; mb = '0; ca = 0; cb = 0;
    cycles = 0;
    repeat (10) begin
      @(negedge clk);
      if (uio_out[6] === 1'b1) cycles++;
    end
    check("t5_no_done", 64'(cycles), 64'd0);
    strobe(4'b0100);
    check("t5_start_empty_err", {63'd0, uio_out[7]}, 64'd1);

    // random operands, random mode, sometimes an extra A byte
    for (int r = 0; r < 6; r++) begin
      sgn   = 1'($urandom_range(0, 1));
      ra    = W'($urandom);
      rb    = W'($urandom);
      extra = int'($urandom_range(0, 1));
      if (extra != 0) wr_byte(1'b0, 8'($urandom));
      load(ra, rb);
      run_op($sformatf("rnd%0d", r), 4'b0100, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
